// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register address and data word widths,
// special register numbers and the matching typedefs.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WORD_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [WORD_W-1:0]     word_t;

endpackage

// File: rtl/regbank_read_port.sv
// One combinational read port of the register bank: $zero, write-through
// bypass from the Writeback port, otherwise the stored word.
module regbank_read_port
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  reg_addr_t          rd_addr,
    input  logic               wr_en,
    input  reg_addr_t          wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH-1:0]   stored_word,
    output logic [WIDTH-1:0]   rd_data
);

    // wr_en arrives already qualified with reset, so the bypass is dead during reset
    always_comb begin
        rd_data = stored_word;
        if (rd_addr == REG_ZERO) begin
            rd_data = '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Architectural register file: one Writeback write port, two Decode read
// ports with write-through bypass, $zero hardwired, $sp given a reset value.
module register_bank
    import mips_pkg::*;
#(
    parameter int unsigned          NREGS    = 32,
    parameter int unsigned          WIDTH    = WORD_W,
    parameter logic [WIDTH-1:0]     SP_RESET = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wb_reg_en,
    input  reg_addr_t           wb_reg_addr,
    input  logic [WIDTH-1:0]    wb_reg_data,
    input  reg_addr_t           id_reg_addr_a,
    input  reg_addr_t           id_reg_addr_b,
    output logic [WIDTH-1:0]    reg_id_data_a,
    output logic [WIDTH-1:0]    reg_id_data_b
);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_en_c;

    // Anything other than a clean 1 on the enable counts as no write
    assign wr_en_c = (wb_reg_en == 1'b1) && !reset;

    // Flop array rather than RAM so that reset can clear every word at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= (i == 32'(REG_SP)) ? SP_RESET : '0;
            end
        end else if (wr_en_c && (wb_reg_addr != REG_ZERO)) begin
            regs[wb_reg_addr] <= wb_reg_data;
        end
    end

    regbank_read_port #(.WIDTH(WIDTH)) u_port_a (
        .rd_addr     (id_reg_addr_a),
        .wr_en       (wr_en_c),
        .wr_addr     (wb_reg_addr),
        .wr_data     (wb_reg_data),
        .stored_word (regs[id_reg_addr_a]),
        .rd_data     (reg_id_data_a)
    );

    regbank_read_port #(.WIDTH(WIDTH)) u_port_b (
        .rd_addr     (id_reg_addr_b),
        .wr_en       (wr_en_c),
        .wr_addr     (wb_reg_addr),
        .wr_data     (wb_reg_data),
        .stored_word (regs[id_reg_addr_b]),
        .rd_data     (reg_id_data_b)
    );

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset values, writes,
// bypass, $zero, async reset, back-to-back writes and an X enable.
module tb_register_bank;

    localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

    logic        clock;
    logic        reset;
    logic        wb_reg_en;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;
    logic [4:0]  id_reg_addr_a;
    logic [4:0]  id_reg_addr_b;
    logic [31:0] reg_id_data_a;
    logic [31:0] reg_id_data_b;

    int n_tests = 0;
    int n_fail  = 0;

    register_bank #(.NREGS(32), .WIDTH(32), .SP_RESET(SP_VAL)) dut (
        .clock         (clock),
        .reset         (reset),
        .wb_reg_en     (wb_reg_en),
        .wb_reg_addr   (wb_reg_addr),
        .wb_reg_data   (wb_reg_data),
        .id_reg_addr_a (id_reg_addr_a),
        .id_reg_addr_b (id_reg_addr_b),
        .reg_id_data_a (reg_id_data_a),
        .reg_id_data_b (reg_id_data_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        wb_reg_en = 1'b0;
        wb_reg_addr = 5'd0;
        wb_reg_data = 32'h0;
        id_reg_addr_a = 5'd29;
        id_reg_addr_b = 5'd5;
        #12;
        check("rst_a_sp", reg_id_data_a, SP_VAL);
        check("rst_b_r5", reg_id_data_b, 32'h0);

        // release reset between edges, then write r2
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_sp", reg_id_data_a, SP_VAL);
        wb_reg_en = 1'b1; wb_reg_addr = 5'd2; wb_reg_data = 32'hFFFFA0EE;
        id_reg_addr_a = 5'd2; id_reg_addr_b = 5'd5;
        @(negedge clock);
        wb_reg_en = 1'b0; wb_reg_data = 32'h0;
        #1;
        check("wr_r2", reg_id_data_a, 32'hFFFFA0EE);
        check("r5_untouched", reg_id_data_b, 32'h0);

        // bypass on both ports
        wb_reg_en = 1'b1; wb_reg_addr = 5'd8; wb_reg_data = 32'h07E8A0EE;
        id_reg_addr_a = 5'd8; id_reg_addr_b = 5'd8;
        #1;
        check("byp_a_r8", reg_id_data_a, 32'h07E8A0EE);
        check("byp_b_r8", reg_id_data_b, 32'h07E8A0EE);
        @(negedge clock);
        wb_reg_en = 1'b0; wb_reg_data = 32'h0;
        #1;
        check("held_a_r8", reg_id_data_a, 32'h07E8A0EE);
        check("held_b_r8", reg_id_data_b, 32'h07E8A0EE);

        // disabled write: neither bypassed nor stored
        wb_reg_en = 1'b0; wb_reg_addr = 5'd30; wb_reg_data = 32'h5538A0AB;
        id_reg_addr_a = 5'd30; id_reg_addr_b = 5'd2;
        #1;
        check("en0_nobyp", reg_id_data_a, 32'h0);
        check("b_r2_during", reg_id_data_b, 32'hFFFFA0EE);
        @(negedge clock);
        #1;
        check("en0_nostore", reg_id_data_a, 32'h0);

        // write to $zero dropped
        wb_reg_en = 1'b1; wb_reg_addr = 5'd0; wb_reg_data = 32'hDEADBEEF;
        id_reg_addr_a = 5'd0; id_reg_addr_b = 5'd0;
        #1;
        check("r0_byp_a", reg_id_data_a, 32'h0);
        check("r0_byp_b", reg_id_data_b, 32'h0);
        @(negedge clock);
        wb_reg_en = 1'b0;
        #1;
        check("r0_after", reg_id_data_a, 32'h0);

        // asynchronous reset mid-cycle clears the array without a clock edge
        id_reg_addr_a = 5'd2; id_reg_addr_b = 5'd29;
        #1;
        check("r2_pre_rst", reg_id_data_a, 32'hFFFFA0EE);
        reset = 1'b1;
        #1;
        check("async_clr_r2", reg_id_data_a, 32'h0);
        check("async_sp", reg_id_data_b, SP_VAL);
        id_reg_addr_b = 5'd8;
        #1;
        check("async_clr_r8", reg_id_data_b, 32'h0);
        wb_reg_en = 1'b1; wb_reg_addr = 5'd2; wb_reg_data = 32'h1234_5678;
        #1;
        check("rst_no_byp", reg_id_data_a, 32'h0);
        @(posedge clock);
        #1;
        check("rst_no_wr", reg_id_data_a, 32'h0);
        @(negedge clock);
        wb_reg_en = 1'b0;
        reset = 1'b0;
        #1;
        check("rel_no_wr", reg_id_data_a, 32'h0);

        // back-to-back writes to r3, port B reads r29 throughout
        @(negedge clock);
        wb_reg_en = 1'b1; wb_reg_addr = 5'd3; wb_reg_data = 32'd1;
        id_reg_addr_a = 5'd3; id_reg_addr_b = 5'd29;
        #1;
        check("b2b_1", reg_id_data_a, 32'd1);
        @(posedge clock);
        #1;
        wb_reg_data = 32'd2;
        #1;
        check("b2b_2", reg_id_data_a, 32'd2);
        @(posedge clock);
        #1;
        wb_reg_data = 32'd3;
        #1;
        check("b2b_3", reg_id_data_a, 32'd3);
        check("b2b_sp", reg_id_data_b, SP_VAL);
        @(posedge clock);
        #1;
        wb_reg_en = 1'b0; wb_reg_data = 32'hFFFF_FFFF;
        #1;
        check("b2b_final", reg_id_data_a, 32'd3);

        // write then overwrite $sp, and an X enable must leave r3 alone
        @(negedge clock);
        wb_reg_en = 1'b1; wb_reg_addr = 5'd29; wb_reg_data = 32'hCAFE_0001;
        @(negedge clock);
        wb_reg_en = 1'bx; wb_reg_addr = 5'd3; wb_reg_data = 32'hBAD0_BAD0;
        @(negedge clock);
        wb_reg_en = 1'b0; wb_reg_addr = 5'd0; wb_reg_data = 32'h0;
        #1;
        check("sp_written", reg_id_data_b, 32'hCAFE_0001);
        check("x_en_keep", reg_id_data_a, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
